// File: rtl/gat_pkg.sv
// Shared types and default sizing for the GAT softmax coefficient path.
// Imported by the coefficient packer, its bank and its bus interface.
package gat_pkg;

  localparam int DEF_DATA_WIDTH   = 8;
  localparam int DEF_NUM_OF_NODES = 5;
  localparam logic [DEF_DATA_WIDTH-1:0] DEF_PAD_VALUE = 8'h80;
  localparam int DEF_CNT_W        = $clog2(DEF_NUM_OF_NODES + 1);

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    DRAIN   = 2'd1,
    HOLD    = 2'd2
  } state_e;

endpackage

// File: rtl/coef_packer_if.sv
// Coefficient beat stream in, packed vector toward softmax out.
// master = upstream/softmax side, slave = packer side.
interface coef_packer_if
  import gat_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int NUM_OF_NODES = DEF_NUM_OF_NODES
);
  localparam int CNT_W = $clog2(NUM_OF_NODES + 1);

  logic                               coef_valid_i;
  logic                               coef_ready_o;
  logic [DATA_WIDTH-1:0]              coef_data_i;
  logic                               coef_last_i;
  logic                               sm_valid_o;
  logic                               sm_ready_i;
  logic [NUM_OF_NODES*DATA_WIDTH-1:0] coef_o;
  logic [CNT_W-1:0]                   num_valid_o;
  logic                               overflow_o;

  modport master (
    output coef_valid_i, coef_data_i, coef_last_i, sm_ready_i,
    input  coef_ready_o, sm_valid_o, coef_o, num_valid_o, overflow_o
  );

  modport slave (
    input  coef_valid_i, coef_data_i, coef_last_i, sm_ready_i,
    output coef_ready_o, sm_valid_o, coef_o, num_valid_o, overflow_o
  );

endinterface

// File: rtl/coef_bank.sv
// NUM_OF_NODES-slot coefficient register file: indexed write, sync clear to PAD,
// flattened read with slot 0 in the MSBs. Single-cycle write, no backpressure.
module coef_bank
  import gat_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int NUM_OF_NODES = DEF_NUM_OF_NODES,
  parameter logic [DATA_WIDTH-1:0] PAD_VALUE = {1'b1, {(DATA_WIDTH-1){1'b0}}}
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               clr_i,
  input  logic                               wr_en_i,
  input  logic [$clog2(NUM_OF_NODES+1)-1:0]  wr_idx_i,
  input  logic [DATA_WIDTH-1:0]              wr_dat_i,
  output logic [NUM_OF_NODES*DATA_WIDTH-1:0] flat_o
);

  logic [DATA_WIDTH-1:0] slot_q [NUM_OF_NODES];
  logic [DATA_WIDTH-1:0] slot_d [NUM_OF_NODES];

  // Clear wins over write; the controller never asks for both on one bank.
  always_comb begin
    slot_d = slot_q;
    if (clr_i) begin
      for (int k = 0; k < NUM_OF_NODES; k++) begin
        slot_d[k] = PAD_VALUE;
      end
    end else if (wr_en_i) begin
      slot_d[wr_idx_i] = wr_dat_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_OF_NODES; k++) begin
        slot_q[k] <= PAD_VALUE;
      end
    end else begin
      slot_q <= slot_d;
    end
  end

  always_comb begin
    flat_o = '0;
    for (int k = 0; k < NUM_OF_NODES; k++) begin
      flat_o[DATA_WIDTH*(NUM_OF_NODES-k)-1 -: DATA_WIDTH] = slot_q[k];
    end
  end

endmodule

// File: rtl/coef_packer.sv
// Packs a valid/ready coefficient stream into a padded vector for softmax; vector valid the cycle after the last beat.
// Input stalls while no bank is free; COEF_PACKER_PING_PONG_EN adds a second bank so collection overlaps the held vector.
module coef_packer
  import gat_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int NUM_OF_NODES = DEF_NUM_OF_NODES,
  parameter logic [DATA_WIDTH-1:0] PAD_VALUE = {1'b1, {(DATA_WIDTH-1){1'b0}}}
) (
  input  logic         clk,
  input  logic         rst,
  coef_packer_if.slave bus
);

  localparam int CNT_W = $clog2(NUM_OF_NODES + 1);
`ifdef COEF_PACKER_PING_PONG_EN
  localparam int NB = 2;
`else
  localparam int NB = 1;
`endif

  function automatic logic flip(input logic b);
    return (NB == 2) ? ~b : 1'b0;
  endfunction

  state_e           state_q, state_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q [NB];
  logic [CNT_W-1:0] cnt_d [NB];
  logic [NB-1:0]    full_q, full_d;
  logic             wr_bank_q, wr_bank_d;
  logic             rd_bank_q, rd_bank_d;
  logic             ready_q, ready_d;
  logic             sm_valid_q, sm_valid_d;
  logic             overflow_q, overflow_d;

  logic                               coef_xfer, sm_xfer;
  logic [NB-1:0]                      bank_wr_en, bank_clr;
  logic [NUM_OF_NODES*DATA_WIDTH-1:0] bank_flat [NB];

  assign coef_xfer = bus.coef_valid_i && ready_q;
  assign sm_xfer   = sm_valid_q && bus.sm_ready_i;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    full_d     = full_q;
    wr_bank_d  = wr_bank_q;
    rd_bank_d  = rd_bank_q;
    overflow_d = overflow_q;
    bank_wr_en = '0;
    bank_clr   = '0;

    // Release the presented bank; it is never the bank being written.
    if (sm_xfer) begin
      full_d[rd_bank_q]   = 1'b0;
      cnt_d[rd_bank_q]    = '0;
      bank_clr[rd_bank_q] = 1'b1;
      rd_bank_d           = flip(rd_bank_q);
    end

    if (coef_xfer) begin
      if (state_q == COLLECT) begin
        bank_wr_en[wr_bank_q] = 1'b1;
        idx_d                 = idx_q + CNT_W'(1);
      end
      if (bus.coef_last_i) begin
        full_d[wr_bank_q] = 1'b1;
        cnt_d[wr_bank_q]  = (state_q == DRAIN) ? CNT_W'(NUM_OF_NODES)
                                               : idx_q + CNT_W'(1);
        wr_bank_d         = flip(wr_bank_q);
        idx_d             = '0;
      end else if (state_q == COLLECT && idx_q == CNT_W'(NUM_OF_NODES - 1)) begin
        state_d    = DRAIN;
        overflow_d = 1'b1;
      end
    end

    // HOLD means the next bank to fill is still occupied.
    if (coef_xfer && bus.coef_last_i) begin
      state_d = full_d[wr_bank_d] ? HOLD : COLLECT;
    end else if (state_q == HOLD && !full_d[wr_bank_q]) begin
      state_d = COLLECT;
    end

    ready_d    = (state_d != HOLD);
    sm_valid_d = full_d[rd_bank_d];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= COLLECT;
      idx_q      <= '0;
      for (int b = 0; b < NB; b++) begin
        cnt_q[b] <= '0;
      end
      full_q     <= '0;
      wr_bank_q  <= 1'b0;
      rd_bank_q  <= 1'b0;
      ready_q    <= 1'b0;
      sm_valid_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      full_q     <= full_d;
      wr_bank_q  <= wr_bank_d;
      rd_bank_q  <= rd_bank_d;
      ready_q    <= ready_d;
      sm_valid_q <= sm_valid_d;
      overflow_q <= overflow_d;
    end
  end

  for (genvar b = 0; b < NB; b++) begin : g_bank
    coef_bank #(
      .DATA_WIDTH  (DATA_WIDTH),
      .NUM_OF_NODES(NUM_OF_NODES),
      .PAD_VALUE   (PAD_VALUE)
    ) u_bank (
      .clk     (clk),
      .rst     (rst),
      .clr_i   (bank_clr[b]),
      .wr_en_i (bank_wr_en[b]),
      .wr_idx_i(idx_q),
      .wr_dat_i(bus.coef_data_i),
      .flat_o  (bank_flat[b])
    );
  end

  assign bus.coef_ready_o = ready_q;
  assign bus.sm_valid_o   = sm_valid_q;
  assign bus.coef_o       = bank_flat[rd_bank_q];
  assign bus.num_valid_o  = cnt_q[rd_bank_q];
  assign bus.overflow_o   = overflow_q;

endmodule

// File: tb/tb_coef_packer.sv
// Directed bench for coef_packer: hand-computed vectors, immediate-assert checks.
// Ping-pong sequence runs only when COEF_PACKER_PING_PONG_EN is defined.
module tb_coef_packer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  coef_packer_if #(.DATA_WIDTH(8), .NUM_OF_NODES(5)) bus ();

  coef_packer #(
    .DATA_WIDTH  (8),
    .NUM_OF_NODES(5),
    .PAD_VALUE   (8'h80)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  localparam logic [39:0] ALL_PAD = 40'h8080808080;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one beat and hold it until it is accepted (bounded wait).
  task automatic send(input logic [7:0] d, input logic l);
    int n;
    n = 0;
    bus.coef_valid_i = 1'b1;
    bus.coef_data_i  = d;
    bus.coef_last_i  = l;
    while (!bus.coef_ready_o && n < 50) begin
      tick();
      n++;
    end
    check("beat_accept", {63'd0, bus.coef_ready_o}, 64'd1);
    tick();
    bus.coef_valid_i = 1'b0;
    bus.coef_last_i  = 1'b0;
  endtask

  initial begin
    rst              = 1'b1;
    bus.coef_valid_i = 1'b0;
    bus.coef_data_i  = 8'h00;
    bus.coef_last_i  = 1'b0;
    bus.sm_ready_i   = 1'b0;
    tick();
    tick();

    check("rst_sm_valid", {63'd0, bus.sm_valid_o}, 64'd0);
    check("rst_ready", {63'd0, bus.coef_ready_o}, 64'd0);
    check("rst_coef", {24'd0, bus.coef_o}, {24'd0, ALL_PAD});
    check("rst_num", {61'd0, bus.num_valid_o}, 64'd0);
    check("rst_overflow", {63'd0, bus.overflow_o}, 64'd0);
    rst = 1'b0;
    tick();
    check("post_rst_ready", {63'd0, bus.coef_ready_o}, 64'd1);

    // Full frame, softmax always ready
    bus.sm_ready_i = 1'b1;
    for (int i = 1; i <= 4; i++) send(8'(i), 1'b0);
    check("t1_valid_before_last", {63'd0, bus.sm_valid_o}, 64'd0);
    send(8'h05, 1'b1);
    check("t1_valid", {63'd0, bus.sm_valid_o}, 64'd1);
    check("t1_coef", {24'd0, bus.coef_o}, 64'h0102030405);
    check("t1_num", {61'd0, bus.num_valid_o}, 64'd5);
    check("t1_overflow", {63'd0, bus.overflow_o}, 64'd0);
    tick();
    check("t1_valid_after", {63'd0, bus.sm_valid_o}, 64'd0);
    check("t1_coef_cleared", {24'd0, bus.coef_o}, {24'd0, ALL_PAD});
    check("t1_num_cleared", {61'd0, bus.num_valid_o}, 64'd0);

    // Short frame, padded, then held under backpressure
    bus.sm_ready_i = 1'b0;
    send(8'h10, 1'b0);
    send(8'h20, 1'b1);
    check("t2_valid", {63'd0, bus.sm_valid_o}, 64'd1);
    check("t2_coef", {24'd0, bus.coef_o}, 64'h1020808080);
    check("t2_num", {61'd0, bus.num_valid_o}, 64'd2);
    for (int c = 0; c < 10; c++) begin
      tick();
      check("t3_hold_coef", {24'd0, bus.coef_o}, 64'h1020808080);
      check("t3_hold_valid", {63'd0, bus.sm_valid_o}, 64'd1);
`ifndef COEF_PACKER_PING_PONG_EN
      check("t3_hold_ready", {63'd0, bus.coef_ready_o}, 64'd0);
`endif
    end
    bus.sm_ready_i = 1'b1;
    tick();
    check("t3_release_valid", {63'd0, bus.sm_valid_o}, 64'd0);
    check("t3_release_ready", {63'd0, bus.coef_ready_o}, 64'd1);

    // Overflow: seven beats, first five kept
    bus.sm_ready_i = 1'b0;
    for (int i = 1; i <= 7; i++) send(8'(i), i == 7);
    check("t4_valid", {63'd0, bus.sm_valid_o}, 64'd1);
    check("t4_coef", {24'd0, bus.coef_o}, 64'h0102030405);
    check("t4_num", {61'd0, bus.num_valid_o}, 64'd5);
    check("t4_overflow", {63'd0, bus.overflow_o}, 64'd1);
    bus.sm_ready_i = 1'b1;
    tick();
    bus.sm_ready_i = 1'b0;
    send(8'h33, 1'b1);
    check("t4_next_coef", {24'd0, bus.coef_o}, 64'h3380808080);
    check("t4_next_num", {61'd0, bus.num_valid_o}, 64'd1);
    check("t4_sticky", {63'd0, bus.overflow_o}, 64'd1);
    bus.sm_ready_i = 1'b1;
    tick();
    check("t4_sticky_after", {63'd0, bus.overflow_o}, 64'd1);

    // Reset in the middle of a frame
    bus.sm_ready_i = 1'b0;
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    send(8'h33, 1'b0);
    rst = 1'b1;
    tick();
    check("t5_rst_valid", {63'd0, bus.sm_valid_o}, 64'd0);
    check("t5_rst_ready", {63'd0, bus.coef_ready_o}, 64'd0);
    check("t5_rst_overflow", {63'd0, bus.overflow_o}, 64'd0);
    check("t5_rst_coef", {24'd0, bus.coef_o}, {24'd0, ALL_PAD});
    rst = 1'b0;
    tick();
    check("t5_no_vector", {63'd0, bus.sm_valid_o}, 64'd0);
    send(8'h7F, 1'b1);
    check("t5_valid", {63'd0, bus.sm_valid_o}, 64'd1);
    check("t5_coef", {24'd0, bus.coef_o}, 64'h7F80808080);
    check("t5_num", {61'd0, bus.num_valid_o}, 64'd1);
    bus.sm_ready_i = 1'b1;
    tick();
    check("t5_done", {63'd0, bus.sm_valid_o}, 64'd0);

`ifdef COEF_PACKER_PING_PONG_EN
    // Two banks filled while softmax stalls, then overlapped release/collect
    bus.sm_ready_i = 1'b0;
    send(8'h01, 1'b1);
    send(8'h02, 1'b1);
    check("t6_ready_full", {63'd0, bus.coef_ready_o}, 64'd0);
    check("t6_first_coef", {24'd0, bus.coef_o}, 64'h0180808080);
    for (int c = 0; c < 5; c++) begin
      tick();
      check("t6_stall_coef", {24'd0, bus.coef_o}, 64'h0180808080);
    end
    bus.sm_ready_i   = 1'b1;
    bus.coef_valid_i = 1'b1;
    bus.coef_data_i  = 8'h03;
    bus.coef_last_i  = 1'b1;
    tick();
    check("t6_second_coef", {24'd0, bus.coef_o}, 64'h0280808080);
    check("t6_second_valid", {63'd0, bus.sm_valid_o}, 64'd1);
    check("t6_ready_again", {63'd0, bus.coef_ready_o}, 64'd1);
    tick();
    bus.coef_valid_i = 1'b0;
    bus.coef_last_i  = 1'b0;
    check("t6_third_coef", {24'd0, bus.coef_o}, 64'h0380808080);
    check("t6_third_valid", {63'd0, bus.sm_valid_o}, 64'd1);
    tick();
    check("t6_drained", {63'd0, bus.sm_valid_o}, 64'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
